// File: rtl/gf_mul_pkg.sv
// Shared widths and FSM encodings for the GF(2^128) multiplier scheduler.
package gf_mul_pkg;

  localparam int GF_W  = 128;
  localparam int CG1_W = 22;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t CALC = 2'd1;
  localparam state_t RESP = 2'd2;

endpackage

// File: rtl/gf_mul_sched_rr_arb.sv
// Combinational round-robin arbiter: picks the first active request after last_ptr.
module rr_arb #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             any_req
);

  int              sum;
  logic [ID_W-1:0] idx;

  // Walk from farthest to nearest so the requester closest after last_ptr wins.
  always_comb begin
    sum       = 0;
    idx       = '0;
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    for (int off = N_REQ; off >= 1; off--) begin
      sum = int'(last_ptr) + off;
      if (sum >= N_REQ) sum = sum - N_REQ;
      idx = ID_W'(sum);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx;
        any_req    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gf_mul_sched.sv
// Shares one gf_mul_128 core between N_REQ requesters; holds operands for a
// fixed multicycle window and returns the reduced product with the owner's ID.
module gf_mul_sched
  import gf_mul_pkg::*;
#(
  parameter int               N_REQ    = 4,
  parameter int               MUL_LAT  = 2,
  parameter logic [CG1_W-1:0] C_G1_RST = 22'h0,
  parameter int               ID_W     = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*GF_W-1:0] req_a,
  input  logic [N_REQ*GF_W-1:0] req_b,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [GF_W-1:0]       rsp_data,
  input  logic                  cfg_valid,
  input  logic [CG1_W-1:0]      cfg_data,
  output logic                  cfg_ready,
  output logic [GF_W-1:0]       mul_a,
  output logic [GF_W-1:0]       mul_b,
  output logic [CG1_W-1:0]      mul_C_g1,
  input  logic [GF_W-1:0]       mul_c,
  output logic                  busy
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [CNT_W-1:0] cnt;
  logic [CG1_W-1:0] c_g1;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;
  logic             any_req;
  logic             idle;

  rr_arb #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req       (req_valid),
    .last_ptr  (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  // A pending config write blocks grants so it lands before the next operation.
  assign idle      = (state == IDLE);
  assign cfg_ready = idle & cfg_valid;
  assign req_ready = (idle && !cfg_valid) ? grant : '0;
  assign rsp_valid = (state == RESP);
  assign busy      = !idle;
  assign mul_C_g1  = c_g1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= ID_W'(N_REQ - 1);
      cnt      <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      c_g1     <= C_G1_RST;
      rsp_data <= '0;
      rsp_id   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            c_g1 <= cfg_data;
          end else if (any_req) begin
            mul_a  <= req_a[int'(grant_idx)*GF_W +: GF_W];
            mul_b  <= req_b[int'(grant_idx)*GF_W +: GF_W];
            rsp_id <= grant_idx;
            rr_ptr <= grant_idx;
            cnt    <= CNT_W'(MUL_LAT - 1);
            state  <= CALC;
          end
        end
        // Core is a multicycle path: sample its output only after MUL_LAT cycles.
        CALC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_data <= mul_c;
            state    <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf_mul_sched.sv
// Self-checking bench for gf_mul_sched: a MUL_LAT=2 instance driven through a
// response scoreboard and a MUL_LAT=1 instance for latency checks.
module tb_gf_mul_sched;

  typedef struct {
    logic [1:0]   id;
    logic [127:0] data;
  } sb_t;

  logic         clk;
  logic         rst_n;

  logic [3:0]   req_valid, req_ready;
  logic [511:0] req_a, req_b;
  logic         rsp_valid, rsp_ready;
  logic [1:0]   rsp_id;
  logic [127:0] rsp_data;
  logic         cfg_valid, cfg_ready;
  logic [21:0]  cfg_data;
  logic [127:0] mul_a, mul_b, mul_c;
  logic [21:0]  mul_C_g1;
  logic         busy;

  logic [3:0]   req_valid_b, req_ready_b;
  logic [511:0] req_a_b, req_b_b;
  logic         rsp_valid_b, rsp_ready_b;
  logic [1:0]   rsp_id_b;
  logic [127:0] rsp_data_b;
  logic         cfg_valid_b, cfg_ready_b;
  logic [21:0]  cfg_data_b;
  logic [127:0] mul_a_b, mul_b_b, mul_c_b;
  logic [21:0]  mul_C_g1_b;
  logic         busy_b;

  int           err_cnt = 0;
  int           chk_cnt = 0;
  int           cyc = 0;
  int           last_g = 3;
  logic [21:0]  cfg_model = 22'h0;
  sb_t          sb_q[$];
  int           g_ids[$];
  int           g_cyc[$];

  // Stand-in for the core: carry-less product of the low halves, xored with C_g1.
  function automatic logic [127:0] core_model(logic [127:0] a, logic [127:0] b, logic [21:0] g);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 64; i++)
      if (b[i]) r = r ^ ({64'b0, a[63:0]} << i);
    return r ^ {106'b0, g};
  endfunction

  function automatic int rr_pick(logic [3:0] v, int last);
    for (int off = 1; off <= 4; off++)
      if (v[(last + off) % 4]) return (last + off) % 4;
    return -1;
  endfunction

  assign mul_c   = core_model(mul_a, mul_b, mul_C_g1);
  assign mul_c_b = core_model(mul_a_b, mul_b_b, mul_C_g1_b);

  gf_mul_sched #(.N_REQ(4), .MUL_LAT(2), .C_G1_RST(22'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_C_g1(mul_C_g1), .mul_c(mul_c), .busy(busy)
  );

  gf_mul_sched #(.N_REQ(4), .MUL_LAT(1), .C_G1_RST(22'h2A)) dut_lat1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_b), .req_a(req_a_b), .req_b(req_b_b), .req_ready(req_ready_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_id(rsp_id_b), .rsp_data(rsp_data_b),
    .cfg_valid(cfg_valid_b), .cfg_data(cfg_data_b), .cfg_ready(cfg_ready_b),
    .mul_a(mul_a_b), .mul_b(mul_b_b), .mul_C_g1(mul_C_g1_b), .mul_c(mul_c_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Grants are checked against a round-robin model; results go to the scoreboard.
  always @(negedge clk) begin
    int  exp_g;
    sb_t e;
    if (rst_n) begin
      if (cfg_valid && cfg_ready) cfg_model = cfg_data;
      if (req_ready != 4'b0) begin
        exp_g = rr_pick(req_valid, last_g);
        if (exp_g < 0) begin
          checkOutput("grant_without_req", 128'(req_ready), 128'h0);
        end else begin
          checkOutput("grant_onehot", 128'(req_ready), 128'(4'b0001 << exp_g));
          last_g = exp_g;
          e.id   = 2'(exp_g);
          e.data = core_model(req_a[exp_g*128 +: 128], req_b[exp_g*128 +: 128], cfg_model);
          sb_q.push_back(e);
          g_ids.push_back(exp_g);
          g_cyc.push_back(cyc);
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          checkOutput("stale_rsp", 128'(rsp_valid), 128'h0);
        end else begin
          e = sb_q.pop_front();
          checkOutput("rsp_id", 128'(rsp_id), 128'(e.id));
          checkOutput("rsp_data", rsp_data, e.data);
        end
      end
    end
  end

  task automatic applyStimulus(input int idx, input logic [127:0] a, input logic [127:0] b);
    @(posedge clk); #1;
    req_a[idx*128 +: 128] = a;
    req_b[idx*128 +: 128] = b;
    req_valid[idx]        = 1'b1;
  endtask

  task automatic drop_req(input int idx);
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_grant(input int idx, output int t);
    @(negedge clk);
    for (int n = 0; n < 40 && !req_ready[idx]; n++) @(negedge clk);
    checkOutput("grant_seen", 128'(req_ready[idx]), 128'h1);
    t = cyc;
  endtask

  task automatic wait_rsp(output int t);
    @(negedge clk);
    for (int n = 0; n < 40 && !rsp_valid; n++) @(negedge clk);
    checkOutput("rsp_seen", 128'(rsp_valid), 128'h1);
    t = cyc;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 60 && sb_q.size() != 0; n++) @(negedge clk);
    checkOutput("drain", 128'(sb_q.size()), 128'h0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb_q.delete();
    last_g    = 3;
    cfg_model = 22'h0;
    rst_n     = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0, t1, t_cfg;
    logic [127:0] a2, b2, exp_d;
    rst_n = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    cfg_valid = 1'b0; cfg_data = '0;
    req_valid_b = '0; req_a_b = '0; req_b_b = '0; rsp_ready_b = 1'b1;
    cfg_valid_b = 1'b0; cfg_data_b = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_rsp_valid", 128'(rsp_valid), 128'h0);
    checkOutput("rst_busy", 128'(busy), 128'h0);
    checkOutput("rst_mul_a", mul_a, 128'h0);
    checkOutput("rst_rsp_data", rsp_data, 128'h0);
    checkOutput("rst_rsp_id", 128'(rsp_id), 128'h0);
    checkOutput("rst_cg1", 128'(mul_C_g1), 128'h0);
    checkOutput("rst_cg1_lat1", 128'(mul_C_g1_b), 128'h2A);
    rst_n = 1'b1;

    $display("[TB] single op");
    applyStimulus(0, 128'h2, 128'h3);
    wait_grant(0, t0);
    drop_req(0);
    wait_rsp(t1);
    checkOutput("lat2_latency", 128'(t1 - t0), 128'd3);
    checkOutput("single_data", rsp_data, 128'h6);
    checkOutput("single_id", 128'(rsp_id), 128'h0);
    wait_drain();

    $display("[TB] fairness");
    do_reset();
    g_ids.delete(); g_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      req_a[i*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
      req_b[i*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
    end
    req_valid = 4'hF;
    for (int n = 0; n < 60 && g_ids.size() < 8; n++) @(negedge clk);
    @(posedge clk); #1;
    req_valid = 4'h0;
    checkOutput("fair_count", 128'(g_ids.size()), 128'd8);
    if (g_ids.size() >= 8) begin
      for (int i = 0; i < 8; i++) checkOutput("fair_order", 128'(g_ids[i]), 128'(i % 4));
      for (int i = 1; i < 8; i++) checkOutput("fair_gap", 128'(g_cyc[i] - g_cyc[i-1]), 128'd4);
    end
    wait_drain();

    $display("[TB] backpressure");
    rsp_ready = 1'b0;
    a2 = 128'h1234_5678_9ABC_DEF0;
    b2 = 128'h0F0F_0000_0000_0101;
    exp_d = core_model(a2, b2, 22'h0);
    applyStimulus(2, a2, b2);
    wait_grant(2, t0);
    @(posedge clk); #1;
    req_valid = 4'b0001;
    wait_rsp(t1);
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_valid", 128'(rsp_valid), 128'h1);
      checkOutput("bp_data", rsp_data, exp_d);
      checkOutput("bp_id", 128'(rsp_id), 128'h2);
      checkOutput("bp_no_grant", 128'(req_ready), 128'h0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_grant(0, t0);
    drop_req(0);
    wait_drain();

    $display("[TB] config vs requests");
    applyStimulus(3, 128'h5, 128'h7);
    wait_grant(3, t0);
    @(posedge clk); #1;
    req_a[128 +: 128] = 128'h9;
    req_b[128 +: 128] = 128'h3;
    req_valid = 4'b0010;
    cfg_valid = 1'b1;
    cfg_data  = 22'h15A5A;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (cfg_ready) break;
      checkOutput("cg1_hold", 128'(mul_C_g1), 128'h0);
    end
    checkOutput("cfg_ready_seen", 128'(cfg_ready), 128'h1);
    checkOutput("cfg_blocks_grant", 128'(req_ready), 128'h0);
    t_cfg = cyc;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    wait_grant(1, t0);
    checkOutput("cfg_then_grant", 128'(t0 - t_cfg), 128'd1);
    drop_req(1);
    @(negedge clk);
    checkOutput("cg1_new", 128'(mul_C_g1), 128'h15A5A);
    wait_drain();

    $display("[TB] reset mid-calc");
    applyStimulus(2, 128'h11, 128'h13);
    wait_grant(2, t0);
    @(posedge clk); #1;
    req_valid = 4'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 128'(rsp_valid), 128'h0);
    checkOutput("mid_rst_mul_a", mul_a, 128'h0);
    checkOutput("mid_rst_cg1", 128'(mul_C_g1), 128'h0);
    checkOutput("mid_rst_busy", 128'(busy), 128'h0);
    sb_q.delete();
    last_g    = 3;
    cfg_model = 22'h0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("no_stale_rsp", 128'(rsp_valid), 128'h0);
    end
    @(posedge clk); #1;
    req_valid = 4'hF;
    @(negedge clk);
    checkOutput("post_rst_grant", 128'(req_ready), 128'h1);
    @(posedge clk); #1;
    req_valid = 4'h0;
    wait_drain();

    $display("[TB] MUL_LAT=1 instance");
    a2 = 128'h0000_0000_0000_0000_8000_0000_0000_0003;
    b2 = 128'h0000_0000_0000_0000_0000_0000_0000_0006;
    exp_d = core_model(a2, b2, 22'h2A);
    @(posedge clk); #1;
    req_a_b[128 +: 128] = a2;
    req_b_b[128 +: 128] = b2;
    req_valid_b = 4'b0010;
    @(negedge clk);
    checkOutput("lat1_grant", 128'(req_ready_b), 128'h2);
    t0 = cyc;
    @(posedge clk); #1;
    req_valid_b = 4'b0;
    @(negedge clk);
    checkOutput("lat1_hold_a", mul_a_b, a2);
    checkOutput("lat1_hold_valid", 128'(rsp_valid_b), 128'h0);
    for (int n = 0; n < 20 && !rsp_valid_b; n++) @(negedge clk);
    checkOutput("lat1_latency", 128'(cyc - t0), 128'd2);
    checkOutput("lat1_data", rsp_data_b, exp_d);
    checkOutput("lat1_id", 128'(rsp_id_b), 128'h1);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
